mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/rr_pick.sv | 23 ++
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-requester latch-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W = 3;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StSample,
    StHold,
    StVerify,
    StDone
  } state_t;

  typedef enum logic {
    ReqA = 1'b0,
    ReqB = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/grant bus and latch-memory port of mem_arbiter.
// master: requesters plus memory (the environment); slave: the arbiter itself.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              req_a;
  logic              req_b;
  logic              wr_a;
  logic              wr_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              ack_a;
  logic              ack_b;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [DATA_W-1:0] mem_d;
  logic [ADDR_W-1:0] mem_sel;
  logic              mem_e;
  logic [DATA_W-1:0] mem_q;

  modport master (
    output req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b, mem_q,
    input  gnt_a, gnt_b, ack_a, ack_b, rdata, err, mem_d, mem_sel, mem_e
  );

  modport slave (
    input  req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b, mem_q,
    output gnt_a, gnt_b, ack_a, ack_b, rdata, err, mem_d, mem_sel, mem_e
  );

endinterface

// File: rtl/rr_pick.sv
// Two-way round-robin choice: on contention the requester not granted last wins.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  req_id_t last,
  output req_id_t winner,
  output logic    valid
);

  // Pick a winner among the active requests.
  always_comb begin
    valid  = req_a | req_b;
    winner = ReqA;
    if (req_a && req_b) begin
      winner = (last == ReqA) ? ReqB : ReqA;
    end else if (req_b) begin
      winner = ReqB;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a 4x3 latch memory with programmable setup/hold
// around a single-cycle write strobe. Define MEM_ARB_READBACK_EN to add a
// post-write readback compare that reports mismatches on err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] SetupLoad = 3'(SETUP_CYC - 1);
  localparam logic [2:0] HoldLoad  = 3'(HOLD_CYC - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  req_id_t           owner_q, owner_d;
  req_id_t           last_q, last_d;
  logic              wr_q, wr_d;
  logic              gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic              ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_d_q, mem_d_d;
  logic [ADDR_W-1:0] mem_sel_q, mem_sel_d;
  logic              mem_e_q, mem_e_d;
  logic              err_q;
  logic              done_go;
  req_id_t           pick_winner;
  logic              pick_valid;
`ifdef MEM_ARB_READBACK_EN
  logic              err_d;
`endif

  rr_pick u_rr_pick (
    .req_a  (bus.req_a),
    .req_b  (bus.req_b),
    .last   (last_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Next-state and next-output logic; every output is a flop loaded from here.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wr_d      = wr_q;
    gnt_a_d   = gnt_a_q;
    gnt_b_d   = gnt_b_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    rdata_d   = rdata_q;
    mem_d_d   = mem_d_q;
    mem_sel_d = mem_sel_q;
    mem_e_d   = 1'b0;
    done_go   = 1'b0;
`ifdef MEM_ARB_READBACK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          cnt_d   = SetupLoad;
          state_d = StSetup;
          if (pick_winner == ReqA) begin
            wr_d      = bus.wr_a;
            mem_sel_d = bus.addr_a;
            mem_d_d   = bus.wdata_a;
            gnt_a_d   = 1'b1;
          end else begin
            wr_d      = bus.wr_b;
            mem_sel_d = bus.addr_b;
            mem_d_d   = bus.wdata_b;
            gnt_b_d   = 1'b1;
          end
        end
      end
      StSetup: begin
        if (cnt_q == 3'd0) begin
          if (wr_q) begin
            state_d = StStrobe;
            mem_e_d = 1'b1;
          end else begin
            state_d = StSample;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StStrobe: begin
        state_d = StHold;
        cnt_d   = HoldLoad;
      end
      StHold: begin
        if (cnt_q == 3'd0) begin
`ifdef MEM_ARB_READBACK_EN
          state_d = StVerify;
`else
          done_go = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StSample: begin
        rdata_d = bus.mem_q;
        done_go = 1'b1;
`ifdef MEM_ARB_READBACK_EN
        err_d   = 1'b0;
`endif
      end
`ifdef MEM_ARB_READBACK_EN
      StVerify: begin
        err_d   = (bus.mem_q != mem_d_q);
        done_go = 1'b1;
      end
`endif
      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Entering DONE: grant drops in the same cycle the ACK pulse appears.
    if (done_go) begin
      state_d = StDone;
      gnt_a_d = 1'b0;
      gnt_b_d = 1'b0;
      ack_a_d = (owner_q == ReqA);
      ack_b_d = (owner_q == ReqB);
    end
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      owner_q   <= ReqA;
      last_q    <= ReqB;
      wr_q      <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      rdata_q   <= '0;
      mem_d_q   <= '0;
      mem_sel_q <= '0;
      mem_e_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      rdata_q   <= rdata_d;
      mem_d_q   <= mem_d_d;
      mem_sel_q <= mem_sel_d;
      mem_e_q   <= mem_e_d;
    end
  end

`ifdef MEM_ARB_READBACK_EN
  // Readback mismatch flag, refreshed at every ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign err_q = 1'b0;
`endif

  assign bus.gnt_a   = gnt_a_q;
  assign bus.gnt_b   = gnt_b_q;
  assign bus.ack_a   = ack_a_q;
  assign bus.ack_b   = ack_b_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign bus.mem_d   = mem_d_q;
  assign bus.mem_sel = mem_sel_q;
  assign bus.mem_e   = mem_e_q;

endmodule
